inst_axi_read_bridge: RTL and testbench

Responder end of the instruction-fetch SRAM-like bus. It accepts one fetch request per transaction from the fetch pipeline and turns it into a 4-beat AXI INCR read burst of 16 aligned bytes. It returns the four words to the second fetch stage as a single-cycle `inst_data_ok` pulse with 128-bit data. It sits between the fetch stages and the AXI crossbar, and never back-pressures the data return.

---
 rtl/inst_axi_read_bridge_if.sv | 40 ++++
 rtl/inst_axi_read_bridge.sv | 118 +++++++++++
 tb/tb_inst_axi_read_bridge.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_axi_read_bridge_if.sv
// Bundle of the fetch-side request/return signals and the AXI read channels (AR, R)
// seen by inst_axi_read_bridge; the bridge uses the slave modport.
interface inst_axi_read_bridge_if;
    // Fetch side: a request moves when inst_req && inst_addr_ok in the same cycle; the
    // return is a one-cycle inst_data_ok pulse that is never stalled. AXI side: a
    // transfer on AR or R happens in any cycle where that channel's valid && ready are 1.
    logic         inst_req;
    logic [31:0]  inst_addr;
    logic         inst_addr_ok;
    logic         inst_data_ok;
    logic [127:0] inst_rdata;
    logic         inst_bus_err;

    logic [3:0]   arid;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         arvalid;
    logic         arready;

    logic [3:0]   rid;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic         rvalid;
    logic         rready;

    modport slave (
        input  inst_req, inst_addr, arready, rid, rdata, rresp, rlast, rvalid,
        output inst_addr_ok, inst_data_ok, inst_rdata, inst_bus_err,
               arid, araddr, arlen, arsize, arburst, arvalid, rready
    );

    modport master (
        output inst_req, inst_addr, arready, rid, rdata, rresp, rlast, rvalid,
        input  inst_addr_ok, inst_data_ok, inst_rdata, inst_bus_err,
               arid, araddr, arlen, arsize, arburst, arvalid, rready
    );
endinterface

// File: rtl/inst_axi_read_bridge.sv
// Instruction-fetch bridge: one fetch request becomes a 4-beat AXI INCR read of an
// aligned 16-byte line, returned as a single 128-bit inst_data_ok pulse.
module inst_axi_read_bridge #(
    parameter logic [3:0] AXI_ID = 4'd0
) (
    input  logic                     clk,
    input  logic                     rst,
    inst_axi_read_bridge_if.slave    bus,
    output logic [1:0]               dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t       state;
    logic [31:0]  araddr_q;
    logic         arvalid_q;
    logic         rready_q;
    logic         data_ok_q;
    logic [127:0] rdata_q;
    logic         bus_err_q;
    logic         err_q;
    logic         full_q;
    logic [1:0]   cnt;
    logic [31:0]  words      [4];
    logic [31:0]  words_next [4];
    logic         beat_ok;
    logic         err_next;
    logic [3:0]   addr_lo_unused;

    assign addr_lo_unused = bus.inst_addr[3:0];

    assign bus.inst_addr_ok = !rst && bus.inst_req && (state == IDLE || state == DONE);
    assign bus.inst_data_ok = data_ok_q;
    assign bus.inst_rdata   = rdata_q;
    assign bus.inst_bus_err = bus_err_q;
    assign bus.arid         = AXI_ID;
    assign bus.araddr       = araddr_q;
    assign bus.arlen        = 8'd3;
    assign bus.arsize       = 3'd2;
    assign bus.arburst      = 2'b01;
    assign bus.arvalid      = arvalid_q;
    assign bus.rready       = rready_q;
    assign dbg_state        = state;

    // Beats tagged with a foreign RID are still drained (rready is high) but ignored.
    assign beat_ok = bus.rvalid && rready_q && (bus.rid == AXI_ID);

    // full_q marks that slot 3 already holds a beat, so another one is an overrun.
    always_comb begin
        words_next      = words;
        words_next[cnt] = bus.rdata;
        err_next        = err_q || (bus.rresp != 2'b00) ||
                          (bus.rlast && cnt != 2'd3) || full_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            data_ok_q <= 1'b0;
            rdata_q   <= '0;
            bus_err_q <= 1'b0;
            err_q     <= 1'b0;
            full_q    <= 1'b0;
            cnt       <= '0;
            for (int i = 0; i < 4; i++) words[i] <= '0;
        end else begin
            data_ok_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.inst_req) begin
                        state     <= AR;
                        araddr_q  <= {bus.inst_addr[31:4], 4'h0};
                        arvalid_q <= 1'b1;
                        err_q     <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
                AR: begin
                    if (arvalid_q && bus.arready) begin
                        state     <= R;
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        cnt       <= '0;
                        full_q    <= 1'b0;
                        for (int i = 0; i < 4; i++) words[i] <= '0;
                    end
                end
                R: begin
                    if (beat_ok) begin
                        for (int i = 0; i < 4; i++) words[i] <= words_next[i];
                        if (cnt == 2'd3) full_q <= 1'b1;
                        else             cnt    <= cnt + 2'd1;
                        err_q <= err_next;
                        if (bus.rlast) begin
                            state     <= DONE;
                            rready_q  <= 1'b0;
                            data_ok_q <= 1'b1;
                            rdata_q   <= {words_next[3], words_next[2],
                                          words_next[1], words_next[0]};
                            bus_err_q <= err_next;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_axi_read_bridge.sv
// Directed bench for inst_axi_read_bridge: inputs change and outputs are checked on the
// falling edge; expected fetch lines are queued by each case and popped at DONE.
module tb_inst_axi_read_bridge;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;
    int         n_cmp = 0;
    int         n_mis = 0;
    logic [127:0] exp_q[$];

    inst_axi_read_bridge_if bus();

    inst_axi_read_bridge #(.AXI_ID(4'd0)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic req_issue(input logic [31:0] addr, input logic [31:0] exp_araddr, input bit hold);
        bus.inst_req  = 1'b1;
        bus.inst_addr = addr;
        #1 check("addr_ok_idle", bus.inst_addr_ok, 1);
        tick();
        if (!hold) bus.inst_req = 1'b0;
        #1;
        check("arvalid_up", bus.arvalid, 1);
        check("araddr", bus.araddr, exp_araddr);
        check("ar_fields", {bus.arid, bus.arlen, bus.arsize, bus.arburst},
              {4'd0, 8'd3, 3'd2, 2'b01});
        check("rready_in_ar", bus.rready, 0);
        check("state_ar", dbg_state, 1);
        check("addr_ok_busy", bus.inst_addr_ok, 0);
    endtask

    task automatic ar_accept(input int stall, input logic [31:0] exp_araddr);
        for (int i = 0; i < stall; i++) begin
            bus.arready = 1'b0;
            tick();
            check("stall_arvalid", bus.arvalid, 1);
            check("stall_araddr", bus.araddr, exp_araddr);
            check("stall_rready", bus.rready, 0);
        end
        bus.arready = 1'b1;
        tick();
        bus.arready = 1'b0;
        check("arvalid_drop", bus.arvalid, 0);
        check("rready_in_r", bus.rready, 1);
        check("state_r", dbg_state, 2);
    endtask

    task automatic beat(input logic [31:0] d, input logic [1:0] resp, input logic last,
                        input logic [3:0] id);
        bus.rvalid = 1'b1;
        bus.rdata  = d;
        bus.rresp  = resp;
        bus.rlast  = last;
        bus.rid    = id;
        tick();
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        bus.rresp  = 2'b00;
        bus.rid    = 4'd0;
        if (!last) check("no_early_data_ok", bus.inst_data_ok, 0);
    endtask

    task automatic done_check(input logic exp_err, input bit next_req,
                              input logic [31:0] next_addr, input logic [31:0] next_araddr);
        logic [127:0] exp_line;
        exp_line = exp_q.pop_front();
        check("data_ok_done", bus.inst_data_ok, 1);
        check("state_done", dbg_state, 3);
        check("rdata", bus.inst_rdata, exp_line);
        check("bus_err", bus.inst_bus_err, exp_err);
        check("rready_done", bus.rready, 0);
        bus.inst_req  = next_req;
        bus.inst_addr = next_addr;
        #1 check("addr_ok_done", bus.inst_addr_ok, next_req);
        tick();
        bus.inst_req = 1'b0;
        check("data_ok_single", bus.inst_data_ok, 0);
        check("rdata_held", bus.inst_rdata, exp_line);
        check("bus_err_held", bus.inst_bus_err, exp_err);
        if (next_req) begin
            check("b2b_arvalid", bus.arvalid, 1);
            check("b2b_araddr", bus.araddr, next_araddr);
            check("b2b_state", dbg_state, 1);
        end else begin
            check("state_idle", dbg_state, 0);
        end
    endtask

    initial begin
        rst         = 1'b1;
        bus.inst_req  = 1'b1;
        bus.inst_addr = 32'h0;
        bus.arready = 1'b0;
        bus.rid     = 4'd0;
        bus.rdata   = 32'h0;
        bus.rresp   = 2'b00;
        bus.rlast   = 1'b0;
        bus.rvalid  = 1'b0;
        tick();
        tick();
        check("rst_addr_ok", bus.inst_addr_ok, 0);
        check("rst_outs", {bus.arvalid, bus.rready, bus.inst_data_ok, bus.inst_bus_err}, 4'b0);
        check("rst_araddr", bus.araddr, 32'h0);
        check("rst_rdata", bus.inst_rdata, 128'h0);
        check("rst_state", dbg_state, 0);
        bus.inst_req = 1'b0;
        rst = 1'b0;
        tick();

        // single fetch
        exp_q.push_back({32'h44, 32'h33, 32'h22, 32'h11});
        req_issue(32'hBFC0_0004, 32'hBFC0_0000, 0);
        ar_accept(0, 32'hBFC0_0000);
        beat(32'h11, 2'b00, 0, 4'd0);
        beat(32'h22, 2'b00, 0, 4'd0);
        beat(32'h33, 2'b00, 0, 4'd0);
        beat(32'h44, 2'b00, 1, 4'd0);
        done_check(0, 0, 32'h0, 32'h0);

        // AR stall, plus an rvalid gap that must not disturb held outputs
        exp_q.push_back({32'hD3, 32'hD2, 32'hD1, 32'hD0});
        req_issue(32'h0000_1234, 32'h0000_1230, 0);
        ar_accept(3, 32'h0000_1230);
        beat(32'hD0, 2'b00, 0, 4'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("gap_data_ok", bus.inst_data_ok, 0);
            check("gap_rdata_held", bus.inst_rdata, {32'h44, 32'h33, 32'h22, 32'h11});
            check("gap_rready", bus.rready, 1);
        end
        beat(32'hD1, 2'b00, 0, 4'd0);
        beat(32'hD2, 2'b00, 0, 4'd0);
        beat(32'hD3, 2'b00, 1, 4'd0);
        done_check(0, 0, 32'h0, 32'h0);

        // back-to-back with inst_req held
        exp_q.push_back({32'hA3, 32'hA2, 32'hA1, 32'hA0});
        exp_q.push_back({32'hB3, 32'hB2, 32'hB1, 32'hB0});
        req_issue(32'h0000_1000, 32'h0000_1000, 1);
        ar_accept(0, 32'h0000_1000);
        #1 check("addr_ok_in_r", bus.inst_addr_ok, 0);
        beat(32'hA0, 2'b00, 0, 4'd0);
        beat(32'hA1, 2'b00, 0, 4'd0);
        beat(32'hA2, 2'b00, 0, 4'd0);
        beat(32'hA3, 2'b00, 1, 4'd0);
        done_check(0, 1, 32'h0000_1010, 32'h0000_1010);
        ar_accept(0, 32'h0000_1010);
        beat(32'hB0, 2'b00, 0, 4'd0);
        beat(32'hB1, 2'b00, 0, 4'd0);
        beat(32'hB2, 2'b00, 0, 4'd0);
        beat(32'hB3, 2'b00, 1, 4'd0);
        done_check(0, 0, 32'h0, 32'h0);

        // SLVERR on the third beat: data still delivered
        exp_q.push_back({32'hE3, 32'hE2, 32'hE1, 32'hE0});
        req_issue(32'h0000_2008, 32'h0000_2000, 0);
        ar_accept(0, 32'h0000_2000);
        beat(32'hE0, 2'b00, 0, 4'd0);
        beat(32'hE1, 2'b00, 0, 4'd0);
        beat(32'hE2, 2'b10, 0, 4'd0);
        beat(32'hE3, 2'b00, 1, 4'd0);
        done_check(1, 0, 32'h0, 32'h0);

        // short burst: rlast on the second beat
        exp_q.push_back({32'h0, 32'h0, 32'hF1, 32'hF0});
        req_issue(32'h0000_3000, 32'h0000_3000, 0);
        ar_accept(1, 32'h0000_3000);
        beat(32'hF0, 2'b00, 0, 4'd0);
        beat(32'hF1, 2'b00, 1, 4'd0);
        done_check(1, 0, 32'h0, 32'h0);

        // foreign RID beat is drained and ignored
        exp_q.push_back({32'hC3, 32'hC2, 32'hC1, 32'hC0});
        req_issue(32'h0000_400C, 32'h0000_4000, 0);
        ar_accept(0, 32'h0000_4000);
        beat(32'hC0, 2'b00, 0, 4'd0);
        beat(32'hDEAD_BEEF, 2'b00, 0, 4'd5);
        beat(32'hC1, 2'b00, 0, 4'd0);
        beat(32'hC2, 2'b00, 0, 4'd0);
        beat(32'hC3, 2'b00, 1, 4'd0);
        done_check(0, 0, 32'h0, 32'h0);

        // overrun: fifth beat overwrites slot 3 and flags an error
        exp_q.push_back({32'h94, 32'h92, 32'h91, 32'h90});
        req_issue(32'h0000_5000, 32'h0000_5000, 0);
        ar_accept(0, 32'h0000_5000);
        beat(32'h90, 2'b00, 0, 4'd0);
        beat(32'h91, 2'b00, 0, 4'd0);
        beat(32'h92, 2'b00, 0, 4'd0);
        beat(32'h93, 2'b00, 0, 4'd0);
        beat(32'h94, 2'b00, 1, 4'd0);
        done_check(1, 0, 32'h0, 32'h0);

        // reset in the middle of R after two beats
        req_issue(32'h0000_6000, 32'h0000_6000, 0);
        ar_accept(0, 32'h0000_6000);
        beat(32'h61, 2'b00, 0, 4'd0);
        beat(32'h62, 2'b00, 0, 4'd0);
        bus.inst_req = 1'b1;
        rst = 1'b1;
        #1;
        check("mid_rst_outs", {bus.arvalid, bus.rready, bus.inst_data_ok, bus.inst_bus_err,
                               bus.inst_addr_ok}, 5'b0);
        check("mid_rst_rdata", bus.inst_rdata, 128'h0);
        check("mid_rst_araddr", bus.araddr, 32'h0);
        check("mid_rst_state", dbg_state, 0);
        tick();
        bus.inst_req = 1'b0;
        rst = 1'b0;
        tick();

        // fresh fetch after reset
        exp_q.push_back({32'h74, 32'h73, 32'h72, 32'h71});
        req_issue(32'h0000_7004, 32'h0000_7000, 0);
        ar_accept(0, 32'h0000_7000);
        beat(32'h71, 2'b00, 0, 4'd0);
        beat(32'h72, 2'b00, 0, 4'd0);
        beat(32'h73, 2'b00, 0, 4'd0);
        beat(32'h74, 2'b00, 1, 4'd0);
        done_check(0, 0, 32'h0, 32'h0);

        check("exp_q_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
